// File: rtl/pong_game_if.sv
// Pong sequencer port bundle: inputs from the debounced buttons and frame timing,
// plus the registered position and score outputs read by the pixel generator.
interface pong_game_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       start;
  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] hit_count;
  logic [1:0] lives;
  logic [1:0] game_st;
  logic       game_over;

  modport slave (
    input  frame_tick, btn_up, btn_down, start,
    output paddle_y, ball_x, ball_y, hit_count, lives, game_st, game_over
  );

  modport master (
    output frame_tick, btn_up, btn_down, start,
    input  paddle_y, ball_x, ball_y, hit_count, lives, game_st, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Per-frame Pong sequencer: moves paddle and ball on each frame tick, resolves
// wall/paddle collisions, counts hits and lives, and runs the game flow.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | power-up, nothing moves, waiting for start
// ST_SERVE | ball held at centre, paddle live, counting serve frames
// ST_PLAY  | paddle and ball move every frame tick
// ST_OVER  | lives exhausted, everything frozen until start
module pong_game_ctrl #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int WALL_X       = 32,
  parameter int PADDLE_X     = 600,
  parameter int PADDLE_W     = 4,
  parameter int PADDLE_H     = 72,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SPEED   = 2,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic         clock,
  input  logic         reset,
  pong_game_if.slave   gif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] PADDLE_RST = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [9:0] PADDLE_MAX = 10'(V_RES - PADDLE_H);
  localparam logic [9:0] PSTEP      = 10'(PADDLE_STEP);
  localparam logic [9:0] BALL_X0    = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0    = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] BOTTOM10   = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] WALL10     = 10'(WALL_X);
  localparam logic [9:0] HIT_X10    = 10'(PADDLE_X - BALL_SIZE);

  localparam logic signed [10:0] S_SPEED  = 11'(BALL_SPEED);
  localparam logic signed [10:0] S_BALL   = 11'(BALL_SIZE);
  localparam logic signed [10:0] S_WALL   = 11'(WALL_X);
  localparam logic signed [10:0] S_BOTTOM = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] S_RIGHT  = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] S_PX     = 11'(PADDLE_X);
  localparam logic signed [10:0] S_PXW    = 11'(PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] S_PH     = 11'(PADDLE_H);

  state_t          state_q, state_d;
  logic [9:0]      paddle_q, paddle_d, paddle_nx;
  logic [9:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic            dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [7:0]      hit_q, hit_d;
  logic [1:0]      lives_q, lives_d;
  logic [CW-1:0]   serve_cnt_q, serve_cnt_d;
  logic            game_over_q;

  logic signed [10:0] bx_step, by_step, py_s;
  logic [9:0]         bx_res, by_res;
  logic               dx_res, dy_res, paddle_hit, miss;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      paddle_q    <= PADDLE_RST;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      dx_neg_q    <= 1'b1;
      dy_neg_q    <= 1'b0;
      hit_q       <= 8'd0;
      lives_q     <= 2'(LIVES);
      serve_cnt_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddle_q    <= paddle_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      hit_q       <= hit_d;
      lives_q     <= lives_d;
      serve_cnt_q <= serve_cnt_d;
      game_over_q <= (state_d == ST_OVER);
    end
  end

  // Paddle candidate for this tick; both or neither button holds position.
  always_comb begin
    paddle_nx = paddle_q;
    if (gif.btn_up && !gif.btn_down)
      paddle_nx = (paddle_q < PSTEP) ? 10'd0 : paddle_q - PSTEP;
    else if (gif.btn_down && !gif.btn_up)
      paddle_nx = (paddle_q > PADDLE_MAX - PSTEP) ? PADDLE_MAX : paddle_q + PSTEP;
  end

  // Ball step and collision resolution, against the already-updated paddle.
  always_comb begin
    bx_step    = $signed({1'b0, ball_x_q}) + (dx_neg_q ? -S_SPEED : S_SPEED);
    by_step    = $signed({1'b0, ball_y_q}) + (dy_neg_q ? -S_SPEED : S_SPEED);
    py_s       = $signed({1'b0, paddle_nx});
    bx_res     = bx_step[9:0];
    by_res     = by_step[9:0];
    dx_res     = dx_neg_q;
    dy_res     = dy_neg_q;
    paddle_hit = 1'b0;
    miss       = 1'b0;

    if (by_step <= 11'sd0) begin
      by_res = 10'd0;
      dy_res = 1'b0;
    end else if (by_step >= S_BOTTOM) begin
      by_res = BOTTOM10;
      dy_res = 1'b1;
    end

    if (bx_step <= S_WALL) begin
      bx_res = WALL10;
      dx_res = 1'b0;
    end else if (!dx_neg_q && (bx_step + S_BALL >= S_PX) && (bx_step + S_BALL <= S_PXW)
                 && (by_step + S_BALL > py_s) && (by_step < py_s + S_PH)
                 && (by_step > 11'sd0) && (by_step < S_BOTTOM)) begin
      paddle_hit = 1'b1;
      bx_res     = HIT_X10;
      dx_res     = 1'b1;
    end else if (!dx_neg_q && (bx_step + S_BALL >= S_PX) && (bx_step + S_BALL <= S_PXW)
                 && ({1'b0, by_res} + S_BALL > py_s) && ({1'b0, by_res} < py_s + S_PH)) begin
      paddle_hit = 1'b1;
      bx_res     = HIT_X10;
      dx_res     = 1'b1;
    end else if (bx_step >= S_RIGHT) begin
      miss = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    paddle_d    = paddle_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    hit_d       = hit_q;
    lives_d     = lives_q;
    serve_cnt_d = serve_cnt_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (gif.start) begin
          state_d     = ST_SERVE;
          lives_d     = 2'(LIVES);
          hit_d       = 8'd0;
          ball_x_d    = BALL_X0;
          ball_y_d    = BALL_Y0;
          dx_neg_d    = 1'b1;
          dy_neg_d    = 1'b0;
          serve_cnt_d = '0;
        end
      end
      ST_SERVE: begin
        if (gif.frame_tick) begin
          paddle_d = paddle_nx;
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          dx_neg_d = 1'b1;
          dy_neg_d = 1'b0;
          if (serve_cnt_q == CW'(SERVE_FRAMES - 1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (gif.frame_tick) begin
          paddle_d = paddle_nx;
          ball_x_d = bx_res;
          ball_y_d = by_res;
          dx_neg_d = dx_res;
          dy_neg_d = dy_res;
          if (paddle_hit && hit_q != 8'hFF)
            hit_d = hit_q + 8'd1;
          if (miss) begin
            if (lives_q > 2'd1) begin
              lives_d     = lives_q - 2'd1;
              state_d     = ST_SERVE;
              ball_x_d    = BALL_X0;
              ball_y_d    = BALL_Y0;
              dx_neg_d    = 1'b1;
              dy_neg_d    = 1'b0;
              serve_cnt_d = '0;
            end else begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gif.paddle_y  = paddle_q;
  assign gif.ball_x    = ball_x_q;
  assign gif.ball_y    = ball_y_q;
  assign gif.hit_count = hit_q;
  assign gif.lives     = lives_q;
  assign gif.game_st   = state_q;
  assign gif.game_over = game_over_q;

endmodule
